// File: rtl/cam_pio_pkg.sv
// Shared types and status-word layout for the camera PIO packer.
package cam_pio_pkg;

    localparam int WORD_W   = 15;
    localparam int SEQ_BIT  = 14;
    localparam int SOF_BIT  = 13;
    localparam int EOL_BIT  = 12;
    localparam int CNT_LSB  = 8;
    localparam int LINE_LSB = 0;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } pix_entry_t;

    typedef enum logic [1:0] {
        FILL,
        PUBLISH,
        WAIT_ACK
    } state_t;

endpackage

// File: rtl/cam_pixel_fifo.sv
// Show-ahead synchronous pixel FIFO; head entry is visible whenever not empty.
module cam_pixel_fifo
    import cam_pio_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  pix_entry_t din,
    output pix_entry_t dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    pix_entry_t     r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_push_ok;
    logic           w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Full is judged on start-of-cycle occupancy, so a same-cycle pop never admits a push.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_pio_packer.sv
// Packs buffered RGB555 pixels plus a status word into PIO registers held
// until software toggles sw_ack.
module cam_pio_packer
    import cam_pio_pkg::*;
#(
    parameter int NUM_PIX    = 9,
    parameter int FIFO_DEPTH = 64,
    parameter int WORD_W     = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pix_valid,
    input  logic [WORD_W-1:0]               pix_data,
    input  logic                            pix_sof,
    input  logic                            pix_eol,
    input  logic                            sw_ack,
    output logic [(NUM_PIX+1)*WORD_W-1:0]   cam_word,
    output logic [7:0]                      ovf_cnt,
    output logic                            busy
);

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  NUM_PIX_C = CNT_W'(NUM_PIX);

    pix_entry_t                         w_din;
    pix_entry_t                         w_head;
    logic                               w_empty;
    logic                               w_full;
    logic                               w_pop;
    logic [CNT_W-1:0]                   w_new_count;
    logic [7:0]                         w_line_base;
    logic [WORD_W-1:0]                  w_status;

    state_t                             r_state;
    logic [WORD_W-1:0]                  r_slot [NUM_PIX];
    logic [CNT_W-1:0]                   r_count;
    logic                               r_b_sof;
    logic                               r_b_eol;
    logic [7:0]                         r_line;
    logic [7:0]                         r_b_line;
    logic                               r_seq;
    logic                               r_ack_q;
    logic                               r_busy;
    logic [7:0]                         r_ovf;
    logic [(NUM_PIX+1)*WORD_W-1:0]      r_word;

    assign w_din = '{sof: pix_sof, eol: pix_eol, data: pix_data};

    cam_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pix_valid),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // A sof head closes a non-empty batch without being consumed.
    assign w_pop       = (r_state == FILL) && !w_empty && !(w_head.sof && (r_count != '0));
    assign w_new_count = r_count + 1'b1;
    assign w_line_base = w_head.sof ? 8'd0 : r_line;

    always_comb begin
        w_status                    = '0;
        w_status[SEQ_BIT]           = ~r_seq;
        w_status[SOF_BIT]           = r_b_sof;
        w_status[EOL_BIT]           = r_b_eol;
        w_status[CNT_LSB +: CNT_W]  = r_count;
        w_status[LINE_LSB +: 8]     = r_b_line;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FILL;
            r_count  <= '0;
            r_b_sof  <= 1'b0;
            r_b_eol  <= 1'b0;
            r_line   <= '0;
            r_b_line <= '0;
            r_seq    <= 1'b0;
            r_ack_q  <= sw_ack;
            r_busy   <= 1'b1;
            r_ovf    <= '0;
            r_word   <= '0;
        end else begin
            if (pix_valid && w_full && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
            case (r_state)
                FILL: begin
                    if (!w_empty) begin
                        if (!w_pop) begin
                            r_state <= PUBLISH;
                        end else begin
                            r_slot[r_count] <= w_head.data;
                            r_count         <= w_new_count;
                            r_b_sof         <= r_b_sof | w_head.sof;
                            r_b_eol         <= r_b_eol | w_head.eol;
                            // Status reports the line before this pixel's own eol bump.
                            r_b_line        <= w_line_base;
                            r_line          <= w_line_base + {7'd0, w_head.eol};
                            if (w_head.eol || (w_new_count == NUM_PIX_C)) begin
                                r_state <= PUBLISH;
                            end
                        end
                    end
                end
                PUBLISH: begin
                    for (int unsigned k = 0; k < NUM_PIX; k++) begin
                        r_word[k*WORD_W +: WORD_W] <= (CNT_W'(k) < r_count) ? r_slot[k] : '0;
                    end
                    r_word[NUM_PIX*WORD_W +: WORD_W] <= w_status;
                    r_seq   <= ~r_seq;
                    r_count <= '0;
                    r_b_sof <= 1'b0;
                    r_b_eol <= 1'b0;
                    r_state <= WAIT_ACK;
                    r_busy  <= 1'b0;
                end
                WAIT_ACK: begin
                    if (sw_ack != r_ack_q) begin
                        r_ack_q <= sw_ack;
                        r_state <= FILL;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign cam_word = r_word;
    assign ovf_cnt  = r_ovf;
    assign busy     = r_busy;

endmodule
